// File: rtl/aes_pkg.sv
// Shared AES datapath widths and the sbox_share_ctrl FSM state encoding.
package aes_pkg;

  localparam int unsigned AES_BYTE_W      = 8;
  localparam int unsigned AES_STATE_W     = 128;
  localparam int unsigned AES_WORD_W      = 32;
  localparam int unsigned AES_STATE_BYTES = AES_STATE_W / AES_BYTE_W;
  localparam int unsigned AES_WORD_BYTES  = AES_WORD_W / AES_BYTE_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN_S = 2'd1;
  localparam logic [1:0] ST_RUN_W = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sbox_share_ctrl_sbox.sv
// Single AES forward sbox lookup, purely combinational.
module sbox_share_ctrl_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = 11'd2047 - {i_data, 3'b000};
  assign o_data    = SBOX_TABLE[w_bit_idx -: 8];

endmodule

// File: rtl/sbox_share_ctrl.sv
// Arbitrates the round datapath and key expansion onto a shared bank of LANES sboxes,
// processing LANES bytes per pass and returning registered results with a done pulse.
module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_req,
  input  logic [AES_STATE_W-1:0] s_in,
  output logic                   s_done,
  output logic [AES_STATE_W-1:0] s_out,
  input  logic                   w_req,
  input  logic [AES_WORD_W-1:0]  w_in,
  output logic                   w_done,
  output logic [AES_WORD_W-1:0]  w_out,
  output logic                   busy
);

  localparam int unsigned STATE_PASSES = AES_STATE_BYTES / LANES;
  localparam int unsigned WORD_PASSES  = AES_WORD_BYTES / LANES;
  localparam int unsigned CNT_W        = (STATE_PASSES > 1) ? $clog2(STATE_PASSES) : 1;
  localparam logic [CNT_W-1:0] S_LAST  = CNT_W'(STATE_PASSES - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WORD_PASSES - 1);

  logic [1:0]             r_state, w_state_d;
  logic [CNT_W-1:0]       r_cnt, w_cnt_d;
  logic [AES_STATE_W-1:0] r_work, w_work_d;
  logic                   r_last_w, w_last_w_d;
  logic                   r_s_done, w_s_done_d;
  logic                   r_w_done, w_w_done_d;
  logic [AES_STATE_W-1:0] r_s_out;
  logic [AES_WORD_W-1:0]  r_w_out;
  logic                   w_grant_w;

  logic [7:0]                 w_lane_in  [LANES];
  logic [7:0]                 w_lane_out [LANES];
  logic [AES_STATE_BYTES-1:0] w_byte_en;
  logic [AES_STATE_W-1:0]     w_byte_val;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_work_d   = r_work;
    w_last_w_d = r_last_w;
    w_s_done_d = 1'b0;
    w_w_done_d = 1'b0;
    w_grant_w  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_req || w_req) begin
          // Ties go to whoever lost the previous tie; single requests leave the flag alone.
          w_grant_w = w_req && (!s_req || !r_last_w);
          if (s_req && w_req) w_last_w_d = w_grant_w;
          w_state_d = w_grant_w ? ST_RUN_W : ST_RUN_S;
          w_work_d  = w_grant_w ? {w_in, {(AES_STATE_W - AES_WORD_W){1'b0}}} : s_in;
          w_cnt_d   = '0;
        end
      end
      ST_RUN_S: begin
        if (r_cnt == S_LAST) begin
          w_state_d  = ST_DONE;
          w_s_done_d = 1'b1;
          w_cnt_d    = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_RUN_W: begin
        if (r_cnt == W_LAST) begin
          w_state_d  = ST_DONE;
          w_w_done_d = 1'b1;
          w_cnt_d    = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Lane i of pass p works on byte p*LANES+i of the working register.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      w_lane_in[i] = r_work[AES_STATE_W - 1 - AES_BYTE_W * (int'(r_cnt) * int'(LANES) + i)
                            -: AES_BYTE_W];
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    sbox_share_ctrl_sbox u_sbox (
      .i_data (w_lane_in[gi]),
      .o_data (w_lane_out[gi])
    );
  end

  always_comb begin
    for (int j = 0; j < int'(AES_STATE_BYTES); j++) begin
      w_byte_en[j] = ((j / int'(LANES)) == int'(r_cnt));
      w_byte_val[AES_STATE_W - 1 - AES_BYTE_W * j -: AES_BYTE_W] = w_lane_out[j % int'(LANES)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_last_w <= 1'b0;
      r_s_done <= 1'b0;
      r_w_done <= 1'b0;
      r_s_out  <= '0;
      r_w_out  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_work   <= w_work_d;
      r_last_w <= w_last_w_d;
      r_s_done <= w_s_done_d;
      r_w_done <= w_w_done_d;
      for (int j = 0; j < int'(AES_STATE_BYTES); j++) begin
        if (r_state == ST_RUN_S && w_byte_en[j]) begin
          r_s_out[AES_STATE_W - 1 - AES_BYTE_W * j -: AES_BYTE_W] <=
            w_byte_val[AES_STATE_W - 1 - AES_BYTE_W * j -: AES_BYTE_W];
        end
      end
      for (int j = 0; j < int'(AES_WORD_BYTES); j++) begin
        if (r_state == ST_RUN_W && w_byte_en[j]) begin
          r_w_out[AES_WORD_W - 1 - AES_BYTE_W * j -: AES_BYTE_W] <=
            w_byte_val[AES_STATE_W - 1 - AES_BYTE_W * j -: AES_BYTE_W];
        end
      end
    end
  end

  assign s_done = r_s_done;
  assign w_done = r_w_done;
  assign s_out  = r_s_out;
  assign w_out  = r_w_out;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Scoreboard bench for sbox_share_ctrl against a GF(2^8) inverse + affine sbox model.
module tb_sbox_share_ctrl;

  parameter int unsigned LANES = 4;
  localparam int S_PASSES = 16 / LANES;
  localparam int W_PASSES = 4 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_req = 1'b0;
  logic [127:0] s_in = '0;
  logic         s_done;
  logic [127:0] s_out;
  logic         w_req = 1'b0;
  logic [31:0]  w_in = '0;
  logic         w_done;
  logic [31:0]  w_out;
  logic         busy;

  sbox_share_ctrl #(.LANES(LANES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_req  (s_req),
    .s_in   (s_in),
    .s_done (s_done),
    .s_out  (s_out),
    .w_req  (w_req),
    .w_in   (w_in),
    .w_done (w_done),
    .w_out  (w_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_w;
    logic [127:0] val;
    int           edge_n;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   m_sb[256];
  bit           m_last_w = 1'b0;
  logic [127:0] m_s_out = '0;
  logic [31:0]  m_w_out = '0;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] sub_bytes(logic [127:0] v, int nbytes);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < nbytes; k++) r[8*k +: 8] = m_sb[v[8*k +: 8]];
    return r;
  endfunction

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_done && w_done) chk("done_exclusive", 1, 0);
      if (s_done || w_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {s_done, w_done}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_port", w_done, e.is_w);
          chk("done_edge", cyc, e.edge_n);
          chk("busy_in_done", busy, 1);
          if (e.is_w) begin
            chk("w_out", w_out, e.val[31:0]);
            chk("s_out_held", s_out, m_s_out);
            m_w_out = e.val[31:0];
          end else begin
            chk("s_out", s_out, e.val);
            chk("w_out_held", w_out, m_w_out);
            m_s_out = e.val;
          end
        end
      end
    end
  end

  function automatic void push_job(bit is_w, logic [127:0] sd, logic [31:0] wd, int done_edge);
    exp_t e;
    e.is_w   = is_w;
    e.val    = is_w ? {96'd0, sub_bytes({96'd0, wd}, 4)[31:0]} : sub_bytes(sd, 16);
    e.edge_n = done_edge;
    exp_q.push_back(e);
  endfunction

  // Caller sits 1ns after a rising edge with the DUT idle; ends in the same position.
  task automatic wait_done();
    int n;
    n = 0;
    while ((s_req || w_req) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (s_done) s_req = 1'b0;
      if (w_done) w_req = 1'b0;
    end
    if (s_req || w_req) begin
      chk("done_timeout", {s_req, w_req}, 0);
      s_req = 1'b0;
      w_req = 1'b0;
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(bit do_s, bit do_w, logic [127:0] sd, logic [31:0] wd, bit scramble);
    bit first_w;
    int e0, d1;
    s_in  = sd;
    w_in  = wd;
    s_req = do_s;
    w_req = do_w;
    e0    = cyc + 1;
    if (do_s && do_w) begin
      first_w  = !m_last_w;
      m_last_w = first_w;
    end else begin
      first_w = do_w;
    end
    d1 = e0 + (first_w ? W_PASSES : S_PASSES);
    push_job(first_w, sd, wd, d1);
    if (do_s && do_w) push_job(!first_w, sd, wd, d1 + 2 + (first_w ? S_PASSES : W_PASSES));
    if (scramble && do_s && !do_w) begin
      @(posedge clk); #1;
      s_in = {$urandom, $urandom, $urandom, $urandom};
      w_in = $urandom;
    end
    wait_done();
  endtask

  initial begin
    logic [127:0] sd;
    logic [31:0]  wd;
    bit           ds, dw;
    int           e0;
    build_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_s_done", s_done, 0);
    chk("rst_w_done", w_done, 0);
    chk("rst_s_out", s_out, 0);
    chk("rst_w_out", w_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(1, 0, 128'h00112233_44556677_8899aabb_ccddeeff, 32'h0, 0);
    run_job(0, 1, 128'h0, 32'hcf4f3c09, 0);
    run_job(1, 1, 128'h00112233_44556677_8899aabb_ccddeeff, 32'hcf4f3c09, 0);
    run_job(1, 1, {$urandom, $urandom, $urandom, $urandom}, $urandom, 0);

    // Reset during pass 2 of a state job; the held request must then rerun in full.
    sd    = {$urandom, $urandom, $urandom, $urandom};
    s_in  = sd;
    s_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_s_out", s_out, 0);
    chk("midrst_w_out", w_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_done", s_done, 0);
    m_last_w = 1'b0;
    m_s_out  = '0;
    m_w_out  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_job(0, sd, 32'h0, e0 + S_PASSES);
    wait_done();

    run_job(1, 0, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1);

    for (int t = 0; t < 24; t++) begin
      ds = $urandom_range(0, 1);
      dw = $urandom_range(0, 1);
      if (!ds && !dw) ds = 1'b1;
      sd = {$urandom, $urandom, $urandom, $urandom};
      wd = $urandom;
      run_job(ds, dw, sd, wd, $urandom_range(0, 1));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
